// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// Single-entry instruction fetch buffer: one outstanding imem read, branch
// redirect with discard of stale responses, downstream freeze.
//
// state   | meaning
// WAIT    | read of req_addr outstanding, data will be buffered
// FULL    | buffer holds an instruction, no read outstanding
// DISCARD | read outstanding whose data is dropped (redirected)
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_reg_q, pc_reg_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT;
            pc_reg_q   <= RESET_PC;
            req_addr_q <= RESET_PC;
            pc_out_q   <= RESET_PC;
            instr_q    <= INSTR_NOP;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_reg_q   <= pc_reg_d;
            req_addr_q <= req_addr_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_reg_d   = pc_reg_q;
        req_addr_d = req_addr_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        unique case (state_q)
            WAIT: begin
                if (branch_taken) begin
                    pc_reg_d = branch_addr;
                    valid_d  = 1'b0;
                    instr_d  = INSTR_NOP;
                    if (imem_ready) begin
                        req_addr_d = branch_addr;
                    end else begin
                        // old read must still complete before the new address is driven
                        state_d = DISCARD;
                    end
                end else if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = req_addr_q + PC_STEP;
                    pc_reg_d = req_addr_q + PC_STEP;
                    valid_d  = 1'b1;
                    state_d  = FULL;
                end
            end
            FULL: begin
                if (branch_taken) begin
                    pc_reg_d   = branch_addr;
                    req_addr_d = branch_addr;
                    valid_d    = 1'b0;
                    instr_d    = INSTR_NOP;
                    state_d    = WAIT;
                end else if (!freeze) begin
                    req_addr_d = pc_reg_q;
                    valid_d    = 1'b0;
                    instr_d    = INSTR_NOP;
                    state_d    = WAIT;
                end
            end
            DISCARD: begin
                if (branch_taken) begin
                    pc_reg_d = branch_addr;
                    valid_d  = 1'b0;
                    instr_d  = INSTR_NOP;
                    if (imem_ready) begin
                        req_addr_d = branch_addr;
                        state_d    = WAIT;
                    end
                end else if (imem_ready) begin
                    req_addr_d = pc_reg_q;
                    state_d    = WAIT;
                end
            end
            default: begin
                state_d = WAIT;
            end
        endcase
    end

    assign imem_addr   = req_addr_q;
    assign imem_rd_en  = !rst && (state_q != FULL);
    assign PC          = pc_out_q;
    assign Instruction = instr_q;
    assign valid       = valid_q;

endmodule
